// File: rtl/imem_boot_loader_if.sv
// Byte-stream and imem write-port bundle for the instruction memory boot loader.
// slave = loader side (consumes the stream, drives the memory write port);
// master = host/memory side.
interface imem_boot_loader_if #(
   parameter int ADDR_W = 7
);
   logic              in_valid;
   logic              in_ready;
   logic [7:0]        in_byte;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;

   modport master (
      output in_valid, in_byte,
      input  in_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  in_valid, in_byte,
      output in_ready, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/imem_boot_loader.sv
// Instruction memory boot loader: parses a LEN(16-bit word count) header from a
// byte stream, writes LEN*4 bytes little-endian from BASE_ADDR upward, checks an
// XOR checksum of the data bytes and keeps the core stalled until a clean load.
module imem_boot_loader #(
   parameter int MEM_BYTES = 128,
   parameter int BASE_ADDR = 0,
   parameter int ADDR_W    = $clog2(MEM_BYTES)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   imem_boot_loader_if.slave    bus,
   output logic                 cpu_stall,
   output logic                 load_done,
   output logic                 load_err,
   output logic [ADDR_W:0]      bytes_loaded
);

   typedef enum logic [2:0] {
      S_LEN_LO,
      S_LEN_HI,
      S_DATA,
      S_CHECK,
      S_DONE,
      S_ERROR
   } state_t;

   localparam logic [17:0] LIMIT = 18'(MEM_BYTES - BASE_ADDR);

   state_t      state, state_next;
   logic [7:0]  len_lo;
   logic [17:0] need;
   logic [17:0] hdr_need;
   logic [7:0]  csum;
   logic        ready;
   logic        accept;
   logic        last_data;

   // Header word count scaled to bytes; 18 bits so LEN*4 never truncates.
   assign hdr_need  = {bus.in_byte, len_lo, 2'b00};
   assign accept    = bus.in_valid & ready;
   assign last_data = ((18'(bytes_loaded) + 18'd1) == need);
   assign bus.in_ready = ready;

   // Stream ready is a pure function of state.
   always_comb begin
      ready = 1'b0;
      case (state)
         S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK: ready = 1'b1;
         default:                             ready = 1'b0;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_LEN_LO;
      else        state <= state_next;
   end

   // Next-state decode.
   always_comb begin
      state_next = state;
      case (state)
         S_LEN_LO: if (accept) state_next = S_LEN_HI;
         S_LEN_HI: begin
            if (accept) begin
               if (hdr_need > LIMIT)       state_next = S_ERROR;
               else if (hdr_need == '0)    state_next = S_CHECK;
               else                        state_next = S_DATA;
            end
         end
         S_DATA:   if (accept && last_data) state_next = S_CHECK;
         S_CHECK: begin
            if (accept) state_next = (bus.in_byte == csum) ? S_DONE : S_ERROR;
         end
         S_DONE, S_ERROR: if (start) state_next = S_LEN_LO;
         default:  state_next = S_LEN_LO;
      endcase
   end

   // Datapath, registered write port and status flags (status follows state_next
   // so the flags change on the same edge as the state).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_lo        <= '0;
         need          <= '0;
         csum          <= '0;
         bytes_loaded  <= '0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         cpu_stall     <= 1'b1;
         load_done     <= 1'b0;
         load_err      <= 1'b0;
      end else begin
         bus.mem_we <= 1'b0;
         cpu_stall  <= (state_next != S_DONE);
         load_done  <= (state_next == S_DONE);
         load_err   <= (state_next == S_ERROR);
         case (state)
            S_LEN_LO: begin
               csum         <= '0;
               bytes_loaded <= '0;
               if (accept) len_lo <= bus.in_byte;
            end
            S_LEN_HI: begin
               if (accept) need <= hdr_need;
            end
            S_DATA: begin
               if (accept) begin
                  csum          <= csum ^ bus.in_byte;
                  bytes_loaded  <= bytes_loaded + 1'b1;
                  bus.mem_we    <= 1'b1;
                  bus.mem_addr  <= ADDR_W'(BASE_ADDR) + bytes_loaded[ADDR_W-1:0];
                  bus.mem_wdata <= bus.in_byte;
               end
            end
            S_DONE, S_ERROR: begin
               // Clear on re-arm so the counters already read zero in LEN_LO.
               if (start) begin
                  csum         <= '0;
                  bytes_loaded <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: a per-cycle vector table for the basic
// frame plus hand-written multi-cycle sequences.
module tb_imem_boot_loader;

   localparam int MEM_BYTES = 128;
   localparam int ADDR_W    = 7;

   logic clk;
   logic rst_n;
   logic start;
   logic cpu_stall;
   logic load_done;
   logic load_err;
   logic [ADDR_W:0] bytes_loaded;

   imem_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

   imem_boot_loader #(
      .MEM_BYTES (MEM_BYTES),
      .BASE_ADDR (0),
      .ADDR_W    (ADDR_W)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .bus          (bus),
      .cpu_stall    (cpu_stall),
      .load_done    (load_done),
      .load_err     (load_err),
      .bytes_loaded (bytes_loaded)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   // Memory model fed by observed writes.
   logic [7:0]  tbmem [MEM_BYTES];
   int unsigned wr_count  = 0;
   int unsigned load_base = 0;
   int unsigned addr_errs = 0;
   logic [ADDR_W-1:0] wr_last = '0;

   always @(negedge clk) begin
      if (bus.mem_we) begin
         tbmem[bus.mem_addr] = bus.mem_wdata;
         if (int'(bus.mem_addr) != int'(wr_count - load_base)) addr_errs++;
         wr_last = bus.mem_addr;
         wr_count++;
      end
   end

   typedef struct {
      logic       start;
      logic       valid;
      logic [7:0] data;
      logic       we;
      logic [6:0] addr;
      logic [7:0] wdata;
      logic       ready;
      logic       done;
      logic       err;
      logic       stall;
      logic [7:0] nbytes;
   } vec_t;

   vec_t vecs [14];

   logic [7:0] f1     [$] = '{8'h02, 8'h00, 8'h13, 8'h01, 8'h50, 8'h00,
                              8'h93, 8'h01, 8'hc0, 8'h00, 8'h10};
   logic [7:0] f1_dat [$] = '{8'h13, 8'h01, 8'h50, 8'h00, 8'h93, 8'h01, 8'hc0, 8'h00};

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      else
         n_pass++;
   endtask

   task automatic send_byte(input logic [7:0] b, input int unsigned max_gap);
      int unsigned gap;
      logic acc;
      gap = (max_gap == 0) ? 0 : $urandom_range(max_gap, 0);
      repeat (gap) begin
         bus.in_valid = 1'b0;
         bus.in_byte  = 8'ha5;
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      bus.in_byte  = b;
      acc = 1'b0;
      for (int t = 0; t < 20 && !acc; t++) begin
         acc = bus.in_ready;
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      if (!acc) check("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic send_frame(input logic [7:0] q [$], input int unsigned max_gap);
      foreach (q[i]) send_byte(q[i], max_gap);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   function automatic int unsigned mem_diffs(input logic [7:0] q [$]);
      int unsigned d = 0;
      foreach (q[i]) if (tbmem[i] !== q[i]) d++;
      return d;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  full [$];
      logic [7:0]  x;
      logic [27:0] got, exp;

      rst_n        = 1'b0;
      start        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_byte  = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      check("reset_state",
            {bus.mem_we, bus.mem_addr, bus.mem_wdata, cpu_stall, load_done, load_err, bytes_loaded, bus.in_ready},
            {1'b0, 7'd0, 8'h00, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1});
      rst_n = 1'b1;
      @(posedge clk); #1;

      // start, valid, data | we, addr, wdata, ready, done, err, stall, bytes
      vecs[0]  = '{1'b0, 1'b1, 8'h02, 1'b0, 7'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0};
      vecs[1]  = '{1'b0, 1'b1, 8'h00, 1'b0, 7'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0};
      vecs[2]  = '{1'b0, 1'b1, 8'h13, 1'b1, 7'd0, 8'h13, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1};
      vecs[3]  = '{1'b0, 1'b1, 8'h01, 1'b1, 7'd1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 8'd2};
      vecs[4]  = '{1'b0, 1'b1, 8'h50, 1'b1, 7'd2, 8'h50, 1'b1, 1'b0, 1'b0, 1'b1, 8'd3};
      vecs[5]  = '{1'b0, 1'b1, 8'h00, 1'b1, 7'd3, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'd4};
      vecs[6]  = '{1'b0, 1'b1, 8'h93, 1'b1, 7'd4, 8'h93, 1'b1, 1'b0, 1'b0, 1'b1, 8'd5};
      vecs[7]  = '{1'b0, 1'b1, 8'h01, 1'b1, 7'd5, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 8'd6};
      vecs[8]  = '{1'b0, 1'b1, 8'hc0, 1'b1, 7'd6, 8'hc0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd7};
      vecs[9]  = '{1'b0, 1'b1, 8'h00, 1'b1, 7'd7, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'd8};
      vecs[10] = '{1'b0, 1'b1, 8'h10, 1'b0, 7'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'd8};
      vecs[11] = '{1'b0, 1'b1, 8'hff, 1'b0, 7'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'd8};
      vecs[12] = '{1'b1, 1'b0, 8'h00, 1'b0, 7'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0};
      vecs[13] = '{1'b0, 1'b1, 8'h02, 1'b0, 7'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0};

      load_base = wr_count;
      for (int i = 0; i < 14; i++) begin
         start        = vecs[i].start;
         bus.in_valid = vecs[i].valid;
         bus.in_byte  = vecs[i].data;
         @(posedge clk); #1;
         got = {bus.mem_we, vecs[i].we ? bus.mem_addr : 7'd0, vecs[i].we ? bus.mem_wdata : 8'h00,
                bus.in_ready, load_done, load_err, cpu_stall, bytes_loaded};
         exp = {vecs[i].we, vecs[i].addr, vecs[i].wdata,
                vecs[i].ready, vecs[i].done, vecs[i].err, vecs[i].stall, vecs[i].nbytes};
         check($sformatf("vec%0d", i), 32'(got), 32'(exp));
      end
      start        = 1'b0;
      bus.in_valid = 1'b0;
      check("f1_writes", wr_count - load_base, 8);
      check("f1_mem", mem_diffs(f1_dat), 0);

      // Bad checksum; start asserted mid-frame must be ignored.
      load_base = wr_count;
      start = 1'b1;
      send_byte(8'h00, 0);
      start = 1'b0;
      send_frame(f1_dat, 0);
      send_byte(8'h11, 0);
      check("bad_csum_status", {load_err, load_done, cpu_stall, bus.in_ready}, {1'b1, 1'b0, 1'b1, 1'b0});
      @(posedge clk); #1;
      check("bad_csum_writes", wr_count - load_base, 8);
      check("bad_csum_addrs", addr_errs, 0);
      pulse_start();
      check("rearm", {load_err, load_done, cpu_stall, bus.in_ready, bytes_loaded}, {1'b1 ^ 1'b1, 1'b0, 1'b1, 1'b1, 8'd0});

      // Oversize header: 33 words exceed 128 bytes.
      load_base = wr_count;
      send_frame('{8'h21, 8'h00}, 0);
      @(posedge clk); #1;
      check("oversize_err", {load_err, cpu_stall, bus.in_ready}, {1'b1, 1'b1, 1'b0});
      check("oversize_writes", wr_count - load_base, 0);
      pulse_start();

      // Full-memory load: 32 words, last write at 127.
      load_base = wr_count;
      full = {};
      x = 8'h00;
      for (int i = 0; i < MEM_BYTES; i++) begin
         full.push_back(8'(i * 7 + 3));
         x ^= 8'(i * 7 + 3);
      end
      send_frame('{8'h20, 8'h00}, 0);
      send_frame(full, 0);
      send_byte(x, 0);
      check("full_status", {load_done, load_err, cpu_stall, bytes_loaded}, {1'b1, 1'b0, 1'b0, 8'd128});
      check("full_no_late_we", bus.mem_we, 0);
      check("full_writes", wr_count - load_base, 128);
      check("full_last_addr", wr_last, 127);
      check("full_mem", mem_diffs(full), 0);
      check("full_addrs", addr_errs, 0);
      pulse_start();

      // Empty load: good then bad checksum.
      load_base = wr_count;
      send_frame('{8'h00, 8'h00, 8'h00}, 0);
      check("empty_done", {load_done, load_err, cpu_stall, bytes_loaded}, {1'b1, 1'b0, 1'b0, 8'd0});
      check("empty_writes", wr_count - load_base, 0);
      pulse_start();
      send_frame('{8'h00, 8'h00, 8'h01}, 0);
      check("empty_err", {load_done, load_err, cpu_stall}, {1'b0, 1'b1, 1'b1});
      pulse_start();

      // Basic frame with random valid gaps.
      load_base = wr_count;
      send_frame(f1, 3);
      check("gap_status", {load_done, load_err, cpu_stall, bytes_loaded}, {1'b1, 1'b0, 1'b0, 8'd8});
      check("gap_writes", wr_count - load_base, 8);
      check("gap_mem", mem_diffs(f1_dat), 0);
      check("gap_addrs", addr_errs, 0);
      pulse_start();

      // Asynchronous reset mid-frame after 3 data bytes.
      load_base = wr_count;
      send_frame('{8'h02, 8'h00, 8'h13, 8'h01, 8'h50}, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset",
            {bus.mem_we, bus.mem_addr, bus.mem_wdata, cpu_stall, load_done, load_err, bytes_loaded, bus.in_ready},
            {1'b0, 7'd0, 8'h00, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1});
      @(negedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      load_base = wr_count;
      send_frame(f1, 0);
      check("reload_status", {load_done, load_err, cpu_stall, bytes_loaded}, {1'b1, 1'b0, 1'b0, 8'd8});
      check("reload_writes", wr_count - load_base, 8);
      check("reload_addrs", addr_errs, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
